// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet RX framer: FSM states, preamble/SFD
// nibble values and bit positions inside the 3-bit frame status word.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_PARK = 3'd0,
    ST_ARM  = 3'd1,
    ST_PRE  = 3'd2,
    ST_DLO  = 3'd3,
    ST_DHI  = 3'd4,
    ST_HUNT = 3'd5
  } state_e;

  localparam logic [3:0] SFD     = 4'hD;
  localparam logic [3:0] PRE_NIB = 4'h5;

  // frame_status = {overflow, long, align}
  localparam int STAT_ALIGN = 0;
  localparam int STAT_LONG  = 1;
  localparam int STAT_OVF   = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (PHY RX_DV).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the raw level through two flops; both clear to 0 on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ethernet_rx_framer.sv
// Ethernet RX framer: arms ethernet_rx once, strips preamble/SFD, packs MII
// nibbles (low first) into bytes for the frame buffer, and reports per-frame
// length and {overflow, long, align} status.
module ethernet_rx_framer
  import eth_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int PRE_MIN = 8,
  parameter int LEN_W   = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ethernet_rx_dv,
  input  logic             nibble_ready,
  input  logic [3:0]       nibble,
  output logic             rx_start,
  input  logic             buf_full,
  output logic             buf_wr,
  output logic [7:0]       buf_data,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic [2:0]       frame_status
);

  localparam logic [LEN_W-1:0] MAX_LEN_C  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LONG_LEN_C = LEN_W'(MAX_LEN + 1);

  logic             dv_s;
  state_e           state_q, state_d;
  logic             armed_q, armed_d;
  logic [3:0]       pre_cnt_q, pre_cnt_d;
  logic [3:0]       lo_q, lo_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [2:0]       stat_q, stat_d;
  logic             rx_start_q, rx_start_d;
  logic             buf_wr_q, buf_wr_d;
  logic [7:0]       buf_data_q, buf_data_d;
  logic             frame_done_q, frame_done_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [2:0]       frame_status_q, frame_status_d;
  logic             have_lo;

  sync_2ff u_dv_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ethernet_rx_dv),
    .q     (dv_s)
  );

  // Next-state logic: nibbles are consumed before end-of-frame is judged,
  // so a nibble arriving with dv_s low still counts toward the frame.
  always_comb begin
    state_d        = state_q;
    armed_d        = armed_q;
    pre_cnt_d      = pre_cnt_q;
    lo_d           = lo_q;
    cnt_d          = cnt_q;
    stat_d         = stat_q;
    rx_start_d     = 1'b0;
    buf_wr_d       = 1'b0;
    buf_data_d     = buf_data_q;
    frame_done_d   = 1'b0;
    frame_len_d    = frame_len_q;
    frame_status_d = frame_status_q;
    have_lo        = 1'b0;

    case (state_q)
      ST_PARK: begin
        // ethernet_rx is only pulsed once per reset; later wakeups skip ARM
        if (enable) state_d = armed_q ? ST_PRE : ST_ARM;
      end

      ST_ARM: begin
        rx_start_d = 1'b1;
        armed_d    = 1'b1;
        state_d    = ST_PRE;
      end

      ST_PRE: begin
        if (!dv_s) begin
          pre_cnt_d = 4'd0;
          if (!enable) state_d = ST_PARK;
        end else if (nibble_ready) begin
          if (nibble == PRE_NIB) begin
            if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
          end else if (nibble == SFD && int'(pre_cnt_q) >= PRE_MIN) begin
            pre_cnt_d = 4'd0;
            cnt_d     = '0;
            stat_d    = 3'b000;
            state_d   = ST_DLO;
          end else begin
            pre_cnt_d = 4'd0;
            state_d   = ST_HUNT;
          end
        end
      end

      ST_DLO, ST_DHI: begin
        have_lo = (state_q == ST_DHI);
        if (nibble_ready) begin
          if (!have_lo) begin
            lo_d    = nibble;
            have_lo = 1'b1;
          end else begin
            have_lo = 1'b0;
            if (cnt_q < MAX_LEN_C) begin
              cnt_d = cnt_q + 1'b1;
              if (buf_full) begin
                stat_d[STAT_OVF] = 1'b1;
              end else if (!stat_q[STAT_OVF]) begin
                buf_wr_d   = 1'b1;
                buf_data_d = {nibble, lo_q};
              end
            end else begin
              cnt_d             = LONG_LEN_C;
              stat_d[STAT_LONG] = 1'b1;
            end
          end
        end
        if (!dv_s) begin
          frame_done_d   = 1'b1;
          frame_len_d    = cnt_d;
          frame_status_d = stat_d;
          if (have_lo) frame_status_d[STAT_ALIGN] = 1'b1;
          state_d = enable ? ST_PRE : ST_PARK;
        end else begin
          state_d = have_lo ? ST_DHI : ST_DLO;
        end
      end

      ST_HUNT: begin
        if (!dv_s) state_d = enable ? ST_PRE : ST_PARK;
      end

      default: state_d = ST_PARK;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_PARK;
      armed_q        <= 1'b0;
      pre_cnt_q      <= 4'd0;
      lo_q           <= 4'd0;
      cnt_q          <= '0;
      stat_q         <= 3'b000;
      rx_start_q     <= 1'b0;
      buf_wr_q       <= 1'b0;
      buf_data_q     <= 8'h00;
      frame_done_q   <= 1'b0;
      frame_len_q    <= '0;
      frame_status_q <= 3'b000;
    end else begin
      state_q        <= state_d;
      armed_q        <= armed_d;
      pre_cnt_q      <= pre_cnt_d;
      lo_q           <= lo_d;
      cnt_q          <= cnt_d;
      stat_q         <= stat_d;
      rx_start_q     <= rx_start_d;
      buf_wr_q       <= buf_wr_d;
      buf_data_q     <= buf_data_d;
      frame_done_q   <= frame_done_d;
      frame_len_q    <= frame_len_d;
      frame_status_q <= frame_status_d;
    end
  end

  assign rx_start     = rx_start_q;
  assign buf_wr       = buf_wr_q;
  assign buf_data     = buf_data_q;
  assign frame_done   = frame_done_q;
  assign frame_len    = frame_len_q;
  assign frame_status = frame_status_q;

endmodule
